// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core types and defaults. commit_rec_t is the record
//                carried on the commit trace stream, used by the core model,
//                the trace arbiter and the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int c_xlen        = 32;
    localparam int c_issue_width = 2;

    // One retired instruction. mem_addr/mem_data only mean something when
    // mem_wrt is set; they are carried as-is otherwise.
    typedef struct packed {
        logic [c_xlen-1:0] pc;
        logic [c_xlen-1:0] instr;
        logic [4:0]        rd;
        logic [c_xlen-1:0] rd_data;
        logic [c_xlen-1:0] mem_addr;
        logic [c_xlen-1:0] mem_data;
        logic              mem_wrt;
    } commit_rec_t;

endpackage
`default_nettype wire

// File: rtl/commit_compact.sv
`default_nettype none
// ============================================================================
//  Module      : commit_compact
//  Description : Combinational lane compactor. For each commit lane gives the
//                number of valid lanes below it (its slot offset from the
//                write pointer) plus the total number of valid lanes.
//  Ports       : i_update  - per-lane retire valid
//                o_offset  - per-lane slot offset (exclusive prefix popcount)
//                o_total   - popcount of i_update
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_compact #(
    parameter int IssueWidth = 2,
    parameter int CountW     = $clog2(IssueWidth + 1)
) (
    input  logic [IssueWidth-1:0]             i_update,
    output logic [IssueWidth-1:0][CountW-1:0] o_offset,
    output logic [CountW-1:0]                 o_total
);

    logic [CountW-1:0] w_acc;

    always_comb begin
        w_acc    = '0;
        o_offset = '0;
        for (int l = 0; l < IssueWidth; l++) begin
            o_offset[l] = w_acc;
            w_acc       = w_acc + CountW'(i_update[l]);
        end
        o_total = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/commit_trace_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_arbiter
//  Description : Buffers up to IssueWidth retired-instruction records per
//                cycle in a circular FIFO and drains them one per cycle, in
//                program order, onto a valid/ready trace stream.
//  Ports       : clk_i, rstn_i (sync, active-low)
//                update_i/pc_i/instr_i/reg_*_i/mem_*_i - commit lanes, lane 0
//                                                       oldest
//                stall_o     - core must not retire this cycle
//                out_valid_o / out_ready_i / out_rec_o - trace stream
//                count_o     - occupied entries
//                overflow_o  - sticky, a commit arrived while stalled
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_arbiter
    import core_pkg::*;
#(
    parameter int IssueWidth = c_issue_width,
    parameter int XLEN       = c_xlen,
    parameter int Depth      = 8
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [IssueWidth-1:0]               update_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     pc_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     instr_i,
    input  logic [IssueWidth-1:0][4:0]          reg_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     reg_data_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     mem_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     mem_data_i,
    input  logic [IssueWidth-1:0]               mem_wrt_i,
    output logic                                stall_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output commit_rec_t                         out_rec_o,
    output logic [$clog2(Depth):0]              count_o,
    output logic                                overflow_o
);

    localparam int c_ptr_w  = $clog2(Depth);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_lane_w = $clog2(IssueWidth + 1);

    commit_rec_t                               r_mem [Depth];
    logic [c_ptr_w-1:0]                        r_wr_ptr;
    logic [c_ptr_w-1:0]                        r_rd_ptr;
    logic [c_cnt_w-1:0]                        r_count;
    logic                                      r_overflow;

    commit_rec_t [IssueWidth-1:0]              w_lane_rec;
    logic [IssueWidth-1:0][c_lane_w-1:0]       w_offset;
    logic [c_lane_w-1:0]                       w_total;
    logic                                      w_any_update;
    logic                                      w_stall;
    logic                                      w_push;
    logic                                      w_pop;
    logic                                      w_valid;
    logic [c_cnt_w-1:0]                        w_push_n;
    logic [c_cnt_w-1:0]                        w_pop_n;

    // Gather each lane's fields into a record; stored unmodified.
    for (genvar l = 0; l < IssueWidth; l++) begin : g_lane
        assign w_lane_rec[l].pc       = pc_i[l];
        assign w_lane_rec[l].instr    = instr_i[l];
        assign w_lane_rec[l].rd       = reg_addr_i[l];
        assign w_lane_rec[l].rd_data  = reg_data_i[l];
        assign w_lane_rec[l].mem_addr = mem_addr_i[l];
        assign w_lane_rec[l].mem_data = mem_data_i[l];
        assign w_lane_rec[l].mem_wrt  = mem_wrt_i[l];
    end

    commit_compact #(
        .IssueWidth (IssueWidth),
        .CountW     (c_lane_w)
    ) u_compact (
        .i_update (update_i),
        .o_offset (w_offset),
        .o_total  (w_total)
    );

    // Stall from registered occupancy only: a pop in this same cycle is not
    // credited, which keeps out_ready_i off the stall path.
    assign w_stall      = (c_cnt_w'(Depth) - r_count) < c_cnt_w'(IssueWidth);
    assign w_any_update = |update_i;
    assign w_push       = w_any_update && !w_stall;
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && out_ready_i;
    assign w_push_n     = w_push ? c_cnt_w'(w_total) : '0;
    assign w_pop_n      = c_cnt_w'(w_pop);

    // Storage is not reset; its contents are only visible while valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            for (int l = 0; l < IssueWidth; l++) begin
                if (update_i[l]) begin
                    r_mem[r_wr_ptr + c_ptr_w'(w_offset[l])] <= w_lane_rec[l];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_total);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + w_push_n - w_pop_n;
            if (w_any_update && w_stall) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign stall_o     = w_stall;
    assign out_valid_o = w_valid;
    assign out_rec_o   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_trace_arbiter
//  Description : Self-checking bench for commit_trace_arbiter. A queue-based
//                reference model follows every clock edge; a compare process
//                checks all outputs on each falling edge. Directed scenarios
//                pin the model with literal expectations, then random traffic
//                with random resets runs against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_arbiter;
    import core_pkg::*;

    localparam int c_depth = 8;
    localparam int c_iw    = 2;

    logic              clk;
    logic              rstn;
    logic [1:0]        update;
    logic [1:0][31:0]  pc, instr, rdd, maddr, mdata;
    logic [1:0][4:0]   ra;
    logic [1:0]        mw;
    logic              ready;
    logic              stall_o, out_valid_o, overflow_o;
    commit_rec_t       out_rec_o;
    logic [3:0]        count_o;

    int n_vec  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    commit_rec_t q[$];
    bit          m_ovf = 0;

    commit_trace_arbiter #(
        .IssueWidth (c_iw),
        .XLEN       (32),
        .Depth      (c_depth)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .update_i    (update),
        .pc_i        (pc),
        .instr_i     (instr),
        .reg_addr_i  (ra),
        .reg_data_i  (rdd),
        .mem_addr_i  (maddr),
        .mem_data_i  (mdata),
        .mem_wrt_i   (mw),
        .stall_o     (stall_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (ready),
        .out_rec_o   (out_rec_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        return (c_depth - q.size()) < c_iw;
    endfunction

    function automatic commit_rec_t lane_rec(input int l);
        commit_rec_t r;
        r.pc = pc[l]; r.instr = instr[l]; r.rd = ra[l]; r.rd_data = rdd[l];
        r.mem_addr = maddr[l]; r.mem_data = mdata[l]; r.mem_wrt = mw[l];
        return r;
    endfunction

    // Reference model: FIFO as a queue, occupancy = queue size.
    always @(posedge clk) begin
        if (!rstn) begin
            q.delete();
            m_ovf = 0;
        end else begin
            bit st, pop;
            st  = m_stall();
            pop = (q.size() != 0) && ready;
            if (pop) void'(q.pop_front());
            if (update != 2'b00) begin
                if (st) m_ovf = 1;
                else begin
                    for (int l = 0; l < c_iw; l++)
                        if (update[l]) q.push_back(lane_rec(l));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            commit_rec_t e;
            e = (q.size() != 0) ? q[0] : '0;
            chk("count_o", count_o, q.size());
            chk("out_valid_o", out_valid_o, q.size() != 0);
            chk("stall_o", stall_o, m_stall());
            chk("overflow_o", overflow_o, m_ovf);
            chk("out_rec_o", out_rec_o, e);
        end
    end

    function automatic commit_rec_t mk(input logic [31:0] p, input logic [4:0] rd, input logic [31:0] d);
        commit_rec_t r;
        r.pc = p; r.instr = p ^ 32'h0000_0013; r.rd = rd; r.rd_data = d;
        r.mem_addr = p + 32'h100; r.mem_data = ~p; r.mem_wrt = p[2];
        return r;
    endfunction

    function automatic commit_rec_t rnd_rec();
        commit_rec_t r;
        r.pc = $urandom; r.instr = $urandom; r.rd = 5'($urandom_range(0, 31));
        r.rd_data = $urandom; r.mem_addr = $urandom; r.mem_data = $urandom;
        r.mem_wrt = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic set_lane(input int l, input commit_rec_t r);
        pc[l] = r.pc; instr[l] = r.instr; ra[l] = r.rd; rdd[l] = r.rd_data;
        maddr[l] = r.mem_addr; mdata[l] = r.mem_data; mw[l] = r.mem_wrt;
    endtask

    task automatic drive(input logic [1:0] upd, input commit_rec_t r0, input commit_rec_t r1);
        update = upd;
        set_lane(0, r0);
        set_lane(1, r1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        commit_rec_t z;
        int acc;
        z = '0;
        rstn = 0; ready = 0;
        drive(2'b00, z, z);
        tick();
        cmp_en = 1;
        tick();
        // Reset state
        chk("rst count", count_o, 0);
        chk("rst valid", out_valid_o, 0);
        chk("rst stall", stall_o, 0);
        chk("rst overflow", overflow_o, 0);
        chk("rst rec", out_rec_o, 0);
        rstn = 1;

        // Single commit
        ready = 1;
        drive(2'b01, mk(32'h8000_0000, 5'd5, 32'h11), z);
        tick();
        drive(2'b00, z, z);
        chk("single valid", out_valid_o, 1);
        chk("single pc", out_rec_o.pc, 32'h8000_0000);
        chk("single rd", out_rec_o.rd, 5);
        chk("single rd_data", out_rec_o.rd_data, 32'h11);
        tick();
        chk("single drained valid", out_valid_o, 0);
        chk("single drained count", count_o, 0);

        // Dual commit
        drive(2'b11, mk(32'h8000_0004, 5'd1, 32'h1), mk(32'h8000_0008, 5'd2, 32'h2));
        tick();
        drive(2'b00, z, z);
        chk("dual first pc", out_rec_o.pc, 32'h8000_0004);
        chk("dual count", count_o, 2);
        tick();
        chk("dual second pc", out_rec_o.pc, 32'h8000_0008);
        tick();
        chk("dual drained", out_valid_o, 0);

        // Hole: lane 1 alone, then lane 0 alone
        drive(2'b10, z, mk(32'h8000_000C, 5'd3, 32'h3));
        tick();
        chk("hole first pc", out_rec_o.pc, 32'h8000_000C);
        drive(2'b01, mk(32'h8000_0010, 5'd4, 32'h4), z);
        tick();
        drive(2'b00, z, z);
        chk("hole second pc", out_rec_o.pc, 32'h8000_0010);
        chk("hole count", count_o, 1);
        tick();
        chk("hole drained", out_valid_o, 0);

        // Fill to 7 and stall
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, mk(32'h8000_0100 + 16 * i, 5'd6, i), mk(32'h8000_0108 + 16 * i, 5'd7, i));
            tick();
        end
        drive(2'b01, mk(32'h8000_0200, 5'd8, 32'h8), z);
        tick();
        chk("fill count", count_o, 7);
        chk("fill stall", stall_o, 1);
        drive(2'b11, mk(32'h8000_0300, 5'd9, 0), mk(32'h8000_0304, 5'd9, 0));
        tick();
        drive(2'b00, z, z);
        chk("drop overflow", overflow_o, 1);
        chk("drop count", count_o, 7);
        chk("drop head pc", out_rec_o.pc, 32'h8000_0100);
        ready = 1;
        tick();
        chk("drain count", count_o, 6);
        chk("drain stall", stall_o, 0);
        chk("drain second pc", out_rec_o.pc, 32'h8000_0108);
        for (int i = 0; i < 6; i++) tick();
        chk("drain empty", count_o, 0);

        // Reset mid-operation at count 5
        ready = 0;
        drive(2'b11, mk(32'h8000_0400, 5'd1, 1), mk(32'h8000_0404, 5'd1, 2));
        tick();
        tick();
        drive(2'b01, mk(32'h8000_0408, 5'd1, 3), z);
        tick();
        drive(2'b00, z, z);
        chk("pre-reset count", count_o, 5);
        rstn = 0;
        tick();
        rstn = 1;
        chk("mid-reset count", count_o, 0);
        chk("mid-reset valid", out_valid_o, 0);
        chk("mid-reset overflow", overflow_o, 0);
        ready = 1;
        drive(2'b01, mk(32'h8000_0500, 5'd10, 32'h55), z);
        tick();
        drive(2'b00, z, z);
        chk("post-reset pc", out_rec_o.pc, 32'h8000_0500);
        chk("post-reset valid", out_valid_o, 1);
        tick();

        // Wrap: 20 accepted dual commits with ready bubbles, honouring stall
        acc = 0;
        for (int c = 0; c < 400 && acc < 20; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            if (!m_stall()) begin
                drive(2'b11, mk(32'h9000_0000 + 8 * acc, 5'(acc), acc),
                             mk(32'h9000_0004 + 8 * acc, 5'(acc + 1), acc + 1));
                acc++;
            end else begin
                drive(2'b00, z, z);
            end
            tick();
        end
        drive(2'b00, z, z);
        chk("wrap accepted", acc, 20);
        ready = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("wrap drained", count_o, 0);
        chk("wrap overflow", overflow_o, 0);

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            rstn  = ($urandom_range(0, 60) != 0);
            ready = ($urandom_range(0, 2) != 0);
            drive(2'($urandom_range(0, 3)), rnd_rec(), rnd_rec());
            tick();
        end
        rstn = 1;
        drive(2'b00, z, z);
        tick();
        cmp_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
